imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 27 ++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and protocol constants for the imem loader
package loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CKSUM = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
  localparam logic [2:0] S_ACK   = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_OK    = 8'h06;
  localparam logic [7:0] ACK_ERR   = 8'h15;

  // States in which a frame is being received and the idle timer runs.
  function automatic logic frame_state(input logic [2:0] s);
    return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CKSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle counter with clear and expiry
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expire
);

  localparam logic [23:0] LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] count;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire = active && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || !active || clear) begin
      count <= '0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART framed instruction-memory loader with checksum and ack
module imem_loader
  import loader_pkg::*;
#(
  parameter int         IMEM_WORDS     = 64,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = loader_pkg::SYNC_BYTE
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_WE,
  output logic [31:0] imem_A,
  output logic [31:0] imem_WD,
  output logic        cpu_stall,
  output logic        cpu_reset,
  output logic        ack_valid,
  output logic [7:0]  ack_data,
  input  logic        ack_ready,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  cksum;
  logic        expire;
  logic        in_frame;
  logic [15:0] len_rx;
  logic        len_bad;

  assign in_frame = frame_state(state);
  assign len_rx   = {rx_data, len_lo};
  assign len_bad  = (len_rx == 16'd0) || ({1'b0, len_rx} > MAX_WORDS);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (CLK),
    .reset (reset),
    .active(in_frame),
    .clear (rx_valid),
    .expire(expire)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      len_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      cksum     <= '0;
      imem_WE   <= 1'b0;
      imem_A    <= '0;
      imem_WD   <= '0;
      cpu_stall <= 1'b0;
      cpu_reset <= 1'b0;
      ack_valid <= 1'b0;
      ack_data  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      imem_WE   <= 1'b0;
      cpu_reset <= 1'b0;
      if (expire) begin
        state    <= S_ERR;
        load_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state     <= S_LEN0;
              cpu_stall <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              word_idx  <= '0;
              byte_idx  <= '0;
              cksum     <= '0;
            end
          end
          S_LEN0: begin
            if (rx_valid) begin
              len_lo <= rx_data;
              state  <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (rx_valid) begin
              n_words <= len_rx;
              if (len_bad) begin
                state    <= S_ERR;
                load_err <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              imem_WD[8*byte_idx +: 8] <= rx_data;
              cksum    <= cksum ^ rx_data;
              byte_idx <= byte_idx + 2'd1;
              // The final lane lands in imem_WD on the same edge the strobe rises.
              if (byte_idx == 2'd3) begin
                imem_WE  <= 1'b1;
                imem_A   <= {14'd0, word_idx, 2'b00};
                word_idx <= word_idx + 16'd1;
                if (word_idx == n_words - 16'd1) begin
                  state <= S_CKSUM;
                end
              end
            end
          end
          S_CKSUM: begin
            if (rx_valid) begin
              if (rx_data == cksum) begin
                state     <= S_DONE;
                cpu_reset <= 1'b1;
                load_done <= 1'b1;
              end else begin
                state    <= S_ERR;
                load_err <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state     <= S_ACK;
            cpu_stall <= 1'b0;
            ack_valid <= 1'b1;
            ack_data  <= ACK_OK;
          end
          S_ERR: begin
            state     <= S_ACK;
            cpu_stall <= 1'b0;
            ack_valid <= 1'b1;
            ack_data  <= ACK_ERR;
          end
          S_ACK: begin
            if (ack_ready) begin
              ack_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

  localparam int IMEM_WORDS = 64;
  localparam int TIMEOUT    = 100;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ack_ready = 1'b0;
  logic        imem_WE;
  logic [31:0] imem_A;
  logic [31:0] imem_WD;
  logic        cpu_stall;
  logic        cpu_reset;
  logic        ack_valid;
  logic [7:0]  ack_data;
  logic        load_done;
  logic        load_err;

  always #5 CLK = ~CLK;

  imem_loader #(
    .IMEM_WORDS(IMEM_WORDS),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_WE(imem_WE), .imem_A(imem_A), .imem_WD(imem_WD),
    .cpu_stall(cpu_stall), .cpu_reset(cpu_reset),
    .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready),
    .load_done(load_done), .load_err(load_err)
  );

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_wr[$];
  wr_t         mon_e;
  logic [7:0]  exp_ack = 8'h15;
  logic [7:0]  pred_cksum;
  int          wr_seen = 0;
  int          rst_seen = 0;
  logic [31:0] last_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Frame-level model: expected word writes, ack byte and success from the raw byte list.
  function automatic logic predict(input bq_t f);
    int   n;
    int   words;
    logic [7:0] x;
    logic good;
    wr_t  e;
    good = 1'b0;
    exp_ack = 8'h15;
    pred_cksum = 8'h00;
    n = int'(f[1]) + 256 * int'(f[2]);
    if (n == 0 || n > IMEM_WORDS) return good;
    words = (f.size() - 3) / 4;
    if (words > n) words = n;
    for (int w = 0; w < words; w++) begin
      e.a = 32'(w * 4);
      e.d = {f[3+4*w+3], f[3+4*w+2], f[3+4*w+1], f[3+4*w]};
      exp_wr.push_back(e);
    end
    if (f.size() == 3 + 4 * n + 1) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) x = x ^ f[3+i];
      pred_cksum = x;
      good = (x == f[3+4*n]);
    end
    if (good) exp_ack = 8'h06;
    return good;
  endfunction

  function automatic bq_t build(input int n, input int seed, input logic bad);
    bq_t f;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    f = {8'hA5, 8'(n), 8'(n >> 8)};
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'(i * 37 + seed);
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(bad ? ~x : x);
    return f;
  endfunction

  always @(negedge CLK) begin
    if (!reset) begin
      if (imem_WE) begin
        wr_seen++;
        last_wd = imem_WD;
        check("addr_bound", 32'(imem_A <= 32'((IMEM_WORDS - 1) * 4)), 32'd1);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", imem_A, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_wr.pop_front();
          check("write_addr", imem_A, mon_e.a);
          check("write_data", imem_WD, mon_e.d);
        end
      end
      if (cpu_reset) rst_seen++;
      if (ack_valid) begin
        check("ack_data", 32'(ack_data), 32'(exp_ack));
        check("stall_in_ack", 32'(cpu_stall), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_all(input bq_t f);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (i == 0) check("stall_set", 32'(cpu_stall), 32'd1);
    end
  endtask

  task automatic wait_ack(input int hold);
    int k;
    k = 0;
    while (!ack_valid && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check("ack_seen", 32'(ack_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      send_byte(i == 0 ? 8'hA5 : 8'(i * 17));
      check("ack_hold_valid", 32'(ack_valid), 32'd1);
      check("ack_hold_data", 32'(ack_data), 32'(exp_ack));
    end
    ack_ready = 1'b1;
    @(posedge CLK);
    #1;
    ack_ready = 1'b0;
    check("ack_release", 32'(ack_valid), 32'd0);
    @(posedge CLK);
    #1;
    check("stall_idle", 32'(cpu_stall), 32'd0);
  endtask

  task automatic run_frame(input bq_t f, input int hold);
    logic good;
    wr_seen = 0;
    rst_seen = 0;
    good = predict(f);
    send_all(f);
    wait_ack(hold);
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("cpu_reset_count", 32'(rst_seen), good ? 32'd1 : 32'd0);
    check("load_done", 32'(load_done), 32'(good));
    check("load_err", 32'(load_err), 32'(!good));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 32'({imem_WE, cpu_stall, cpu_reset, ack_valid, load_done, load_err}), 32'd0);
    check({tag, "_addr"}, imem_A, 32'd0);
    check({tag, "_wd"}, imem_WD, 32'd0);
    check({tag, "_ack_data"}, 32'(ack_data), 32'd0);
  endtask

  initial begin
    bq_t f;
    logic good;
    int cyc;
    int acks;

    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset_state");
    reset = 1'b0;
    @(posedge CLK);
    #1;

    // Single-word good frame with hand-computed word and checksum.
    f = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    run_frame(f, 0);
    check("lit_word", last_wd, 32'h00A00513);
    check("lit_cksum", 32'(pred_cksum), 32'h0000_00B6);
    check("lit_ack_ok", 32'(exp_ack), 32'h06);
    check("lit_one_write", 32'(wr_seen), 32'd1);

    // Three words, wrong checksum: payload XOR is 07, 08 is sent.
    f = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
         8'h04, 8'h00, 8'h00, 8'h00, 8'h08};
    run_frame(f, 0);
    check("lit_three_writes", 32'(wr_seen), 32'd3);
    check("lit_ack_err", 32'(exp_ack), 32'h15);

    // Length boundaries rejected right after LEN_HI.
    f = {8'hA5, 8'h00, 8'h00};
    run_frame(f, 0);
    check("len0_writes", 32'(wr_seen), 32'd0);
    f = {8'hA5, 8'h41, 8'h00};
    run_frame(f, 0);
    check("len65_writes", 32'(wr_seen), 32'd0);

    // Idle timeout mid-word.
    f = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h05};
    wr_seen = 0;
    rst_seen = 0;
    good = predict(f);
    send_all(f);
    cyc = 0;
    while (!load_err && cyc < 300) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'd100);
    check("stall_in_err", 32'(cpu_stall), 32'd1);
    @(posedge CLK);
    #1;
    check("stall_drop", 32'(cpu_stall), 32'd0);
    check("ack_after_err", 32'(ack_valid), 32'd1);
    wait_ack(0);
    check("timeout_writes", 32'(wr_seen), 32'd0);
    check("timeout_err", 32'(load_err), 32'(!good));

    // Reset after two words of a four-word frame.
    f = build(4, 11, 1'b0);
    f = f[0:10];
    wr_seen = 0;
    good = predict(f);
    send_all(f);
    @(negedge CLK);
    #1;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    check_zero("midframe_reset");
    reset = 1'b0;
    check("reset_writes", 32'(wr_seen), 32'd2);
    check("reset_drained", 32'(exp_wr.size()), 32'd0);
    acks = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (ack_valid || imem_WE) acks++;
    end
    check("reset_no_ack", 32'(acks), 32'd0);
    run_frame(build(4, 11, 1'b0), 0);
    check("reload_writes", 32'(wr_seen), 32'd4);

    // Full-capacity frame with the ack held off while extra bytes arrive.
    run_frame(build(IMEM_WORDS, 5, 1'b0), 10);
    check("full_writes", 32'(wr_seen), 32'(IMEM_WORDS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
